// File: rtl/sort_serializer.sv
// Output stage behind the sort network: buffers up to two sorted vectors and
// streams their elements out one per handshake, element 0 first.
module sort_serializer #(
  parameter int DATA_WIDTH = 4,
  parameter int LOG_INPUT  = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     x_valid,
  input  logic [0:DATA_WIDTH*(1<<LOG_INPUT)-1]     x,
  output logic [DATA_WIDTH-1:0]                    m_data,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic                                     m_last,
  output logic [LOG_INPUT-1:0]                     m_index,
  output logic                                     overflow
);

  localparam int N  = 1 << LOG_INPUT;
  localparam int VW = DATA_WIDTH * N;

  // The buffer occupancy doubles as the FSM state.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [0:VW-1]          r_slot [2];
  logic                   r_wrPtr;
  logic                   r_rdPtr;
  logic [1:0]             r_state;
  logic [LOG_INPUT-1:0]   r_elemIdx;
  logic                   r_overflow;

  logic                   w_hs;
  logic                   w_lastElem;
  logic                   w_lastHs;
  logic                   w_capture;
  logic                   w_drop;
  logic [0:VW-1]          w_cur;
  logic [DATA_WIDTH-1:0]  w_data;

  assign w_hs       = m_valid && m_ready;
  assign w_lastElem = (r_elemIdx == LOG_INPUT'(N - 1));
  assign w_lastHs   = w_hs && w_lastElem;
  // A full buffer still accepts a vector when its oldest slot frees this edge.
  assign w_capture  = x_valid && ((r_state != S_TWO) || w_lastHs);
  assign w_drop     = x_valid && (r_state == S_TWO) && !w_lastHs;

  assign w_cur = r_slot[r_rdPtr];

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_elemIdx == LOG_INPUT'(i)) begin
        w_data = w_cur[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_valid  = (r_state != S_EMPTY);
  assign m_data   = w_data;
  assign m_index  = r_elemIdx;
  assign m_last   = m_valid && w_lastElem;
  assign overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot[0]  <= '0;
      r_slot[1]  <= '0;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_state    <= S_EMPTY;
      r_elemIdx  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_slot[r_wrPtr] <= x;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_hs) begin
        if (w_lastElem) begin
          r_elemIdx <= '0;
          r_rdPtr   <= ~r_rdPtr;
        end else begin
          r_elemIdx <= r_elemIdx + 1'b1;
        end
      end
      case (r_state)
        S_EMPTY: if (w_capture) r_state <= S_ONE;
        S_ONE: begin
          if (w_capture && !w_lastHs)      r_state <= S_TWO;
          else if (!w_capture && w_lastHs) r_state <= S_EMPTY;
        end
        S_TWO: if (!w_capture && w_lastHs) r_state <= S_ONE;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_serializer.sv
// Scoreboard bench for sort_serializer: accepted vectors queue their expected
// elements, and the output monitor checks every valid cycle against the head.
module tb_sort_serializer;

  logic        clk;
  logic        rst;
  logic        x_valid;
  logic [0:31] x;
  logic [3:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [2:0]  m_index;
  logic        overflow;

  int compared;
  int mismatched;
  logic [7:0] expQ[$];

  sort_serializer #(.DATA_WIDTH(4), .LOG_INPUT(3)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_index(m_index), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one vector for one edge; accepted vectors queue {last,index,data} per element.
  task automatic applyStimulus(input logic [31:0] v, input bit expectAccept);
    x       = v;
    x_valid = 1'b1;
    if (expectAccept) begin
      for (int i = 0; i < 8; i++) begin
        logic [3:0] nib;
        nib = 4'((v >> (28 - 4*i)) & 32'hF);
        expQ.push_back({(i == 7) ? 1'b1 : 1'b0, 3'(i), nib});
      end
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while ((expQ.size() != 0 || m_valid) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 200) checkOutput("drainTimeout", 32'(expQ.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedValid", 1, 0);
      end else begin
        checkOutput("element", {24'd0, m_last, m_index, m_data}, {24'd0, expQ[0]});
        if (m_ready) void'(expQ.pop_front());
      end
    end
  end

  localparam logic [31:0] VEC_A = 32'h01234567;
  localparam logic [31:0] VEC_B = 32'h89ABCDEF;
  localparam logic [31:0] VEC_C = 32'h55AA33CC;
  localparam logic [31:0] VEC_D = 32'h0F1E2D3C;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst     = 1'b1;
    x_valid = 1'b0;
    x       = '0;
    m_ready = 1'b0;
    #1;
    checkOutput("resetValid", 32'(m_valid), 0);
    checkOutput("resetOuts", {m_last, m_index, m_data, overflow}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset mid-stream clears everything at once.
    m_ready = 1'b1;
    applyStimulus(VEC_A, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midResetValid", 32'(m_valid), 0);
    checkOutput("midResetOuts", {m_last, m_index, m_data, overflow}, 0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idleValid", 32'(m_valid), 0);
    end
    @(posedge clk);
    #1;

    // Single vector, one-cycle latency.
    applyStimulus(VEC_A, 1'b1);
    checkOutput("latencyValid", 32'(m_valid), 1);
    checkOutput("latencyData", 32'(m_data), 0);
    waitDrain();

    // Backpressure pattern 1,0,0 repeating.
    m_ready = 1'b1;
    applyStimulus(VEC_A, 1'b1);
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 3 == 0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    waitDrain();

    // Back-to-back vectors stream with no bubble.
    applyStimulus(VEC_A, 1'b1);
    applyStimulus(VEC_B, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("noBubble", 32'(m_valid), 1);
    end
    @(negedge clk);
    checkOutput("b2bEnd", 32'(m_valid), 0);
    checkOutput("b2bOverflow", 32'(overflow), 0);
    @(posedge clk);
    #1;

    // Overflow: third vector into a full stalled buffer is dropped.
    m_ready = 1'b0;
    applyStimulus(VEC_A, 1'b1);
    applyStimulus(VEC_B, 1'b1);
    checkOutput("preDropOverflow", 32'(overflow), 0);
    applyStimulus(VEC_C, 1'b0);
    checkOutput("dropOverflow", 32'(overflow), 1);
    m_ready = 1'b1;
    waitDrain();
    checkOutput("stickyOverflow", 32'(overflow), 1);

    rst = 1'b1;
    #1;
    checkOutput("overflowCleared", 32'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Capture on the same edge as the last handshake of a full buffer.
    m_ready = 1'b0;
    applyStimulus(VEC_A, 1'b1);
    applyStimulus(VEC_B, 1'b1);
    m_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(VEC_D, 1'b1);
    checkOutput("simulOverflow", 32'(overflow), 0);
    waitDrain();
    checkOutput("simulOverflowEnd", 32'(overflow), 0);
    checkOutput("queueEmpty", 32'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
